axi_ram_fill: RTL and testbench
===============================

# axi_ram_fill

AXI4 write-only master that fills a contiguous word region of an `axi_ram` instance with a constant or incrementing pattern. It replaces simulation-only initial loops with a synthesizable, run-time fill, for example clearing scratch buffers between jobs. It sits between a control/CSR block and the RAM's write channels (AW/W/B). The read channels are untouched and can be used concurrently.

## Interface
- DATA_WIDTH, 32, data bus width (bits)
- ADDR_WIDTH, 16, byte address width
- STRB_WIDTH, DATA_WIDTH/8, wstrb width; power of two
- LEN_WIDTH, 8, awlen width
- COUNT_WIDTH, 16, word-count width
- MAX_BURST, 16, max beats per burst; 1..2**LEN_WIDTH
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous assert, active-low
- start  in  1  fill request pulse; only honoured when busy=0
- base_addr  in  ADDR_WIDTH  byte start address; low log2(STRB_WIDTH) bits ignored, treated as 0
- word_count  in  COUNT_WIDTH  words to write; 0 is legal
- pattern  in  DATA_WIDTH  fill value
- busy  out  1  fill in progress
- done  out  1  one-cycle completion pulse
- err  out  1  sticky, set when any bresp != OKAY
- m_axi_awaddr  out  ADDR_WIDTH  burst address
- m_axi_awlen  out  LEN_WIDTH  beats-1
- m_axi_awsize  out  3  constant log2(STRB_WIDTH)
- m_axi_awburst  out  2  constant INCR (2'b01)
- m_axi_awvalid / m_axi_awready  out / in  1  AW handshake
- m_axi_wdata  out  DATA_WIDTH  beat data
- m_axi_wstrb  out  STRB_WIDTH  constant all-ones
- m_axi_wlast  out  1  final beat of burst
- m_axi_wvalid / m_axi_wready  out / in  1  W handshake
- m_axi_bresp  in  2  write response
- m_axi_bvalid / m_axi_bready  in / out  1  B handshake

## Operation
- FSM states:
  - IDLE: accepts start, then goes to AW (word_count>0) or DONE (word_count=0). Captures base_addr, word_count and pattern; clears err and the word index.
  - AW: drives awvalid. Moves to W on handshake.
  - W: drives wvalid. Advances on each handshake; wlast marks the final beat. Moves to B after the wlast handshake.
  - B: bready=1. On handshake, sets err if bresp != 2'b00. Goes to AW if words remain, otherwise DONE.
  - DONE: done=1 for one cycle, then IDLE.
- Only one burst is outstanding at a time. No AW is issued before the previous B is received.
- Burst beats = min(remaining, MAX_BURST, words to the next 4 KiB boundary).
  - Words to boundary = (4096 − addr[11:0]) >> log2(STRB_WIDTH).
  - The boundary term is unused when ADDR_WIDTH < 12.
- After each B: address advances by beats·STRB_WIDTH (wraps modulo 2^ADDR_WIDTH); remaining decreases by beats.
- A bresp error does not abort the fill; the remaining bursts are still issued.
- start while busy=1 is ignored.

## Timing
- Reset values: busy=0, done=0, err=0, awvalid=0, wvalid=0, wlast=0, bready=0. awaddr, awlen and wdata reset to 0.
- awvalid rises the cycle after start is accepted. awaddr and awlen are stable while awvalid=1.
- wvalid rises the cycle after the AW handshake. wdata/wlast hold until wready.
- bready is high only in B.
- busy is 1 in AW/W/B/DONE.
- word_count=0: done pulses 2 cycles after start (via DONE) and no AXI traffic occurs.
- Reset mid-operation: all valids drop immediately, FSM returns to IDLE, and the partial fill is abandoned. No done pulse is produced.
- Burst overhead: 1 AW cycle + N W cycles + B latency, with no idle cycle between B and the next AW.

## Configuration
- AXI_RAM_FILL_INCR_EN defined: beat k of the fill carries pattern + k, where k is the global word index from 0 and wraps modulo 2^DATA_WIDTH.
- AXI_RAM_FILL_INCR_EN undefined: every beat carries pattern, and the index adder is not instantiated.

## Structure
- Shared package axi_ram_pkg holds:
  - AXI_BURST_INCR = 2'b01 and AXI_RESP_OKAY = 2'b00
  - fill FSM state enum (IDLE, AW, W, B, DONE)
  - 4 KiB boundary constant
- One sub-module, axi_ram_fill_len: a combinational burst-length calculator. Inputs are current address and remaining words; output is awlen. It is reusable by a future read-scrub engine.

## Test plan
- DATA_WIDTH=32, MAX_BURST=16, base 0x0000, count 40 → three bursts:
  - 0x0000 len 15
  - 0x0040 len 15
  - 0x0080 len 7
  - RAM words 0–39 = pattern, done once, err=0.
- base 0x0FF0, count 8 → 0x0FF0 len 3, then 0x1000 len 3. No burst crosses 0x1000.
- count 0 → no awvalid; done pulses 2 cycles after start; busy high 1 cycle.
- Second of three bursts returns bresp=2'b10 → err=1 sticky, third burst still issued, done pulses. The next start clears err.
- pattern 0x1000, count 4, random wready stalls:
  - with macro → RAM holds 0x1000, 0x1001, 0x1002, 0x1003
  - without macro → all four words hold 0x1000
- rst_n low mid-W of a 16-beat burst → awvalid/wvalid/busy drop immediately. After release, a new start completes normally.

Source files
------------

// File: rtl/axi_ram_pkg.sv
// Shared AXI constants and fill FSM state encoding for the axi_ram helpers.
package axi_ram_pkg;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
    localparam int unsigned AXI_4K_BYTES  = 4096;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_AW,
        ST_W,
        ST_B,
        ST_DONE
    } fill_state_e;

endpackage

// File: rtl/axi_ram_fill_len.sv
// Burst length calculator: min(remaining, MAX_BURST, words to next 4 KiB page).
module axi_ram_fill_len
    import axi_ram_pkg::*;
#(
    parameter int ADDR_WIDTH  = 16,
    parameter int STRB_WIDTH  = 4,
    parameter int LEN_WIDTH   = 8,
    parameter int COUNT_WIDTH = 16,
    parameter int MAX_BURST   = 16
) (
    input  logic [ADDR_WIDTH-1:0]  addr_i,
    input  logic [COUNT_WIDTH-1:0] rem_i,
    output logic [LEN_WIDTH-1:0]   len_o
);

    localparam int SZ = $clog2(STRB_WIDTH);
    localparam int CW = (COUNT_WIDTH > 13) ? COUNT_WIDTH + 1 : 14;

    logic [CW-1:0] rem_w;
    logic [CW-1:0] bnd_w;
    logic [CW-1:0] beats;

    assign rem_w = CW'(rem_i);

    generate
        if (ADDR_WIDTH >= 12) begin : g_bnd
            assign bnd_w = CW'((32'(AXI_4K_BYTES)
                           - 32'(addr_i & ADDR_WIDTH'(4095))) >> SZ);
        end else begin : g_nobnd
            assign bnd_w = '1;
        end
    endgenerate

    always_comb begin
        beats = rem_w;
        if (beats > CW'(MAX_BURST)) beats = CW'(MAX_BURST);
        if (beats > bnd_w) beats = bnd_w;
        len_o = LEN_WIDTH'(beats - CW'(1));
    end

endmodule

// File: rtl/axi_ram_fill.sv
// AXI4 write-only region filler; AXI_RAM_FILL_INCR_EN selects incrementing data.
module axi_ram_fill
    import axi_ram_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 16,
    parameter int STRB_WIDTH  = DATA_WIDTH / 8,
    parameter int LEN_WIDTH   = 8,
    parameter int COUNT_WIDTH = 16,
    parameter int MAX_BURST   = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [ADDR_WIDTH-1:0]  base_addr,
    input  logic [COUNT_WIDTH-1:0] word_count,
    input  logic [DATA_WIDTH-1:0]  pattern,
    output logic                   busy,
    output logic                   done,
    output logic                   err,
    output logic [ADDR_WIDTH-1:0]  m_axi_awaddr,
    output logic [LEN_WIDTH-1:0]   m_axi_awlen,
    output logic [2:0]             m_axi_awsize,
    output logic [1:0]             m_axi_awburst,
    output logic                   m_axi_awvalid,
    input  logic                   m_axi_awready,
    output logic [DATA_WIDTH-1:0]  m_axi_wdata,
    output logic [STRB_WIDTH-1:0]  m_axi_wstrb,
    output logic                   m_axi_wlast,
    output logic                   m_axi_wvalid,
    input  logic                   m_axi_wready,
    input  logic [1:0]             m_axi_bresp,
    input  logic                   m_axi_bvalid,
    output logic                   m_axi_bready
);

    localparam int SZ = $clog2(STRB_WIDTH);

    fill_state_e            state_q;
    logic [ADDR_WIDTH-1:0]  awaddr_q, addr_d, len_addr;
    logic [COUNT_WIDTH-1:0] rem_q, rem_d, len_rem;
    logic [LEN_WIDTH-1:0]   awlen_q, beat_q, len_calc;
    logic [DATA_WIDTH-1:0]  wdata_q;
    logic busy_q, done_q, err_q;
    logic awvalid_q, wvalid_q, wlast_q, bready_q;

    // Next burst start, valid while in B; IDLE feeds the calculator from inputs.
    assign addr_d = awaddr_q
                  + ((ADDR_WIDTH'(awlen_q) + ADDR_WIDTH'(1)) << SZ);
    assign rem_d  = rem_q - (COUNT_WIDTH'(awlen_q) + COUNT_WIDTH'(1));

    assign len_addr = (state_q == ST_IDLE)
                    ? (base_addr & ~ADDR_WIDTH'(STRB_WIDTH - 1))
                    : addr_d;
    assign len_rem  = (state_q == ST_IDLE) ? word_count : rem_d;

    axi_ram_fill_len #(
        .ADDR_WIDTH  (ADDR_WIDTH),
        .STRB_WIDTH  (STRB_WIDTH),
        .LEN_WIDTH   (LEN_WIDTH),
        .COUNT_WIDTH (COUNT_WIDTH),
        .MAX_BURST   (MAX_BURST)
    ) u_len (
        .addr_i (len_addr),
        .rem_i  (len_rem),
        .len_o  (len_calc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            awaddr_q  <= '0;
            awlen_q   <= '0;
            beat_q    <= '0;
            rem_q     <= '0;
            wdata_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            wlast_q   <= 1'b0;
            bready_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        err_q    <= 1'b0;
                        busy_q   <= 1'b1;
                        rem_q    <= word_count;
                        wdata_q  <= pattern;
                        awaddr_q <= len_addr;
                        awlen_q  <= len_calc;
                        if (word_count == '0) begin
                            state_q <= ST_DONE;
                        end else begin
                            awvalid_q <= 1'b1;
                            state_q   <= ST_AW;
                        end
                    end
                end
                ST_AW: begin
                    if (m_axi_awready) begin
                        awvalid_q <= 1'b0;
                        wvalid_q  <= 1'b1;
                        beat_q    <= awlen_q;
                        wlast_q   <= (awlen_q == '0);
                        state_q   <= ST_W;
                    end
                end
                ST_W: begin
                    if (m_axi_wready) begin
`ifdef AXI_RAM_FILL_INCR_EN
                        wdata_q <= wdata_q + DATA_WIDTH'(1);
`endif
                        if (wlast_q) begin
                            wvalid_q <= 1'b0;
                            wlast_q  <= 1'b0;
                            bready_q <= 1'b1;
                            state_q  <= ST_B;
                        end else begin
                            beat_q  <= beat_q - LEN_WIDTH'(1);
                            wlast_q <= (beat_q == LEN_WIDTH'(1));
                        end
                    end
                end
                ST_B: begin
                    if (m_axi_bvalid) begin
                        bready_q <= 1'b0;
                        rem_q    <= rem_d;
                        if (m_axi_bresp != AXI_RESP_OKAY) err_q <= 1'b1;
                        if (rem_d == '0) begin
                            state_q <= ST_DONE;
                        end else begin
                            awaddr_q  <= len_addr;
                            awlen_q   <= len_calc;
                            awvalid_q <= 1'b1;
                            state_q   <= ST_AW;
                        end
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign err           = err_q;
    assign m_axi_awaddr  = awaddr_q;
    assign m_axi_awlen   = awlen_q;
    assign m_axi_awsize  = 3'(SZ);
    assign m_axi_awburst = AXI_BURST_INCR;
    assign m_axi_awvalid = awvalid_q;
    assign m_axi_wdata   = wdata_q;
    assign m_axi_wstrb   = '1;
    assign m_axi_wlast   = wlast_q;
    assign m_axi_wvalid  = wvalid_q;
    assign m_axi_bready  = bready_q;

endmodule

// File: tb/tb_axi_ram_fill.sv
// Directed bench for axi_ram_fill with a behavioural AXI write slave and RAM.
module tb_axi_ram_fill;

    localparam logic [31:0] SENT = 32'h5A5A_5A5A;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] base_addr;
    logic [15:0] word_count;
    logic [31:0] pattern;
    logic        busy, done, err;
    logic [15:0] m_axi_awaddr;
    logic [7:0]  m_axi_awlen;
    logic [2:0]  m_axi_awsize;
    logic [1:0]  m_axi_awburst;
    logic        m_axi_awvalid, m_axi_awready;
    logic [31:0] m_axi_wdata;
    logic [3:0]  m_axi_wstrb;
    logic        m_axi_wlast, m_axi_wvalid, m_axi_wready;
    logic [1:0]  m_axi_bresp;
    logic        m_axi_bvalid, m_axi_bready;

    always #5 clk = ~clk;

    axi_ram_fill dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .base_addr     (base_addr),
        .word_count    (word_count),
        .pattern       (pattern),
        .busy          (busy),
        .done          (done),
        .err           (err),
        .m_axi_awaddr  (m_axi_awaddr),
        .m_axi_awlen   (m_axi_awlen),
        .m_axi_awsize  (m_axi_awsize),
        .m_axi_awburst (m_axi_awburst),
        .m_axi_awvalid (m_axi_awvalid),
        .m_axi_awready (m_axi_awready),
        .m_axi_wdata   (m_axi_wdata),
        .m_axi_wstrb   (m_axi_wstrb),
        .m_axi_wlast   (m_axi_wlast),
        .m_axi_wvalid  (m_axi_wvalid),
        .m_axi_wready  (m_axi_wready),
        .m_axi_bresp   (m_axi_bresp),
        .m_axi_bvalid  (m_axi_bvalid),
        .m_axi_bready  (m_axi_bready)
    );

    logic [31:0] mem [0:16383];
    int          log_addr [0:31];
    int          log_len  [0:31];
    int          nb, done_cnt, aw_cyc, w_beat, cur_len, bad_burst;
    int          b_wait, wlast_bad;
    bit          bhs, stall_en;
    logic [15:0] cur_addr;
    int          vec_cnt, err_cnt;

    task automatic chk(input string name, input longint act, input longint exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] exp_word(input logic [31:0] p, input int k);
`ifdef AXI_RAM_FILL_INCR_EN
        return p + 32'(k);
`else
        return p + 32'(k) * 32'd0;
`endif
    endfunction

    // Slave bookkeeping sees pre-edge values of the DUT outputs.
    always @(posedge clk) begin
        if (!rst_n) begin
            b_wait = 0;
            bhs    = 1'b0;
            w_beat = 0;
        end else begin
            if (done) done_cnt++;
            if (m_axi_awvalid) aw_cyc++;
            if (m_axi_awvalid && m_axi_awready) begin
                cur_addr = m_axi_awaddr;
                cur_len  = int'(m_axi_awlen);
                w_beat   = 0;
                if (nb < 32) begin
                    log_addr[nb] = int'(m_axi_awaddr);
                    log_len[nb]  = int'(m_axi_awlen);
                end
                nb++;
            end
            if (m_axi_wvalid && m_axi_wready) begin
                mem[(int'(cur_addr >> 2) + w_beat) & 16383] = m_axi_wdata;
                if (m_axi_wlast !== (w_beat == cur_len)) wlast_bad++;
                w_beat++;
                if (m_axi_wlast) b_wait = 2;
            end
            if (m_axi_bvalid && m_axi_bready) bhs = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            m_axi_bvalid  = 1'b0;
            m_axi_bresp   = 2'b00;
            m_axi_awready = 1'b0;
            m_axi_wready  = 1'b0;
        end else begin
            m_axi_awready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
            m_axi_wready  = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
            if (bhs) begin
                m_axi_bvalid = 1'b0;
                bhs = 1'b0;
            end
            if (b_wait > 0) begin
                b_wait--;
                if (b_wait == 0) begin
                    m_axi_bvalid = 1'b1;
                    m_axi_bresp  = (nb - 1 == bad_burst) ? 2'b10 : 2'b00;
                end
            end
        end
    end

    task automatic run_fill(input logic [15:0] b, input logic [15:0] c,
                            input logic [31:0] p, input string nm);
        bit ok;
        @(negedge clk);
        nb = 0; done_cnt = 0; wlast_bad = 0; aw_cyc = 0;
        start = 1'b1; base_addr = b; word_count = c; pattern = p;
        @(negedge clk);
        start = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (done_cnt > 0) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
        chk({nm, " done_timeout"}, longint'(ok), 1);
    endtask

    typedef struct {
        logic [15:0] base;
        logic [15:0] cnt;
        logic [31:0] pat;
        int          nbursts;
        int          a0, a1, a2;
        int          l0, l1, l2;
    } vec_t;

    vec_t vecs [5];

    initial begin
        int ea [3];
        int el [3];
        int bad;
        int wa;
        vec_cnt = 0; err_cnt = 0; bad_burst = -1; stall_en = 1'b0;
        nb = 0; done_cnt = 0; aw_cyc = 0; wlast_bad = 0; w_beat = 0;
        cur_len = 0; cur_addr = '0; b_wait = 0; bhs = 1'b0;
        rst_n = 1'b0; start = 1'b0;
        base_addr = '0; word_count = '0; pattern = '0;
        for (int i = 0; i < 16384; i++) mem[i] = SENT;

        vecs[0] = '{16'h0000, 16'd40, 32'hA5A5_0000, 3,
                    'h0000, 'h0040, 'h0080, 15, 15, 7};
        vecs[1] = '{16'h0FF0, 16'd8, 32'h0000_1234, 2,
                    'h0FF0, 'h1000, 0, 3, 3, 0};
        vecs[2] = '{16'h0103, 16'd5, 32'hDEAD_BEEF, 1,
                    'h0100, 0, 0, 4, 0, 0};
        vecs[3] = '{16'h2000, 16'd1, 32'h0BAD_F00D, 1,
                    'h2000, 0, 0, 0, 0, 0};
        vecs[4] = '{16'h3FC0, 16'd20, 32'hFFFF_FFFE, 2,
                    'h3FC0, 'h4000, 0, 15, 3, 0};

        #12;
        chk("rst busy", longint'(busy), 0);
        chk("rst done", longint'(done), 0);
        chk("rst err", longint'(err), 0);
        chk("rst awvalid", longint'(m_axi_awvalid), 0);
        chk("rst wvalid", longint'(m_axi_wvalid), 0);
        chk("rst wlast", longint'(m_axi_wlast), 0);
        chk("rst bready", longint'(m_axi_bready), 0);
        chk("rst awaddr", longint'(m_axi_awaddr), 0);
        chk("rst awlen", longint'(m_axi_awlen), 0);
        chk("rst wdata", longint'(m_axi_wdata), 0);
        chk("awsize", longint'(m_axi_awsize), 2);
        chk("awburst", longint'(m_axi_awburst), 1);
        chk("wstrb", longint'(m_axi_wstrb), 'hF);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int v = 0; v < 5; v++) begin
            ea[0] = vecs[v].a0; ea[1] = vecs[v].a1; ea[2] = vecs[v].a2;
            el[0] = vecs[v].l0; el[1] = vecs[v].l1; el[2] = vecs[v].l2;
            run_fill(vecs[v].base, vecs[v].cnt, vecs[v].pat, $sformatf("v%0d", v));
            chk($sformatf("v%0d nbursts", v), longint'(nb), longint'(vecs[v].nbursts));
            for (int j = 0; j < vecs[v].nbursts; j++) begin
                chk($sformatf("v%0d b%0d addr", v, j), longint'(log_addr[j]), longint'(ea[j]));
                chk($sformatf("v%0d b%0d len", v, j), longint'(log_len[j]), longint'(el[j]));
            end
            chk($sformatf("v%0d done_cnt", v), longint'(done_cnt), 1);
            chk($sformatf("v%0d err", v), longint'(err), 0);
            chk($sformatf("v%0d busy", v), longint'(busy), 0);
            chk($sformatf("v%0d wlast", v), longint'(wlast_bad), 0);
            wa = int'(vecs[v].base) >> 2;
            bad = 0;
            for (int k = 0; k < int'(vecs[v].cnt); k++)
                if (mem[wa + k] !== exp_word(vecs[v].pat, k)) bad++;
            chk($sformatf("v%0d bad_words", v), longint'(bad), 0);
            chk($sformatf("v%0d sentinel", v),
                longint'(mem[wa + int'(vecs[v].cnt)]), longint'(SENT));
        end

        @(negedge clk);
        aw_cyc = 0; nb = 0; done_cnt = 0;
        start = 1'b1; word_count = 16'd0; base_addr = 16'h0800;
        @(negedge clk);
        start = 1'b0;
        chk("z busy1", longint'(busy), 1);
        chk("z done1", longint'(done), 0);
        @(negedge clk);
        chk("z busy2", longint'(busy), 0);
        chk("z done2", longint'(done), 1);
        @(negedge clk);
        chk("z done3", longint'(done), 0);
        chk("z awvalid", longint'(aw_cyc), 0);
        chk("z nbursts", longint'(nb), 0);

        bad_burst = 1;
        run_fill(16'h0000, 16'd40, 32'h0000_0077, "e");
        chk("e err", longint'(err), 1);
        chk("e nbursts", longint'(nb), 3);
        chk("e b2 addr", longint'(log_addr[2]), 'h0080);
        chk("e done_cnt", longint'(done_cnt), 1);
        bad_burst = -1;
        run_fill(16'h0600, 16'd1, 32'h0000_0001, "e2");
        chk("e2 err", longint'(err), 0);

        stall_en = 1'b1;
        run_fill(16'h0200, 16'd4, 32'h0000_1000, "inc");
        stall_en = 1'b0;
        for (int k = 0; k < 4; k++)
            chk($sformatf("inc w%0d", k), longint'(mem[('h200 >> 2) + k]),
                longint'(exp_word(32'h0000_1000, k)));
        chk("inc wlast", longint'(wlast_bad), 0);

        @(negedge clk);
        nb = 0; done_cnt = 0;
        start = 1'b1; base_addr = 16'h0400; word_count = 16'd16; pattern = 32'h0;
        @(negedge clk);
        start = 1'b0;
        begin
            bit hit;
            hit = 1'b0;
            for (int i = 0; i < 200; i++) begin
                if (w_beat >= 5) begin
                    hit = 1'b1;
                    break;
                end
                @(negedge clk);
            end
            chk("r reach_w", longint'(hit), 1);
        end
        chk("r pre wvalid", longint'(m_axi_wvalid), 1);
        rst_n = 1'b0;
        #1;
        chk("r awvalid", longint'(m_axi_awvalid), 0);
        chk("r wvalid", longint'(m_axi_wvalid), 0);
        chk("r busy", longint'(busy), 0);
        chk("r bready", longint'(m_axi_bready), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("r no_done", longint'(done_cnt), 0);
        run_fill(16'h0500, 16'd3, 32'h0000_00C3, "r2");
        chk("r2 nbursts", longint'(nb), 1);
        chk("r2 addr", longint'(log_addr[0]), 'h0500);
        chk("r2 len", longint'(log_len[0]), 2);
        chk("r2 w2", longint'(mem[('h500 >> 2) + 2]),
            longint'(exp_word(32'h0000_00C3, 2)));

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
